// File: rtl/sram_burst_req.sv
// Burst request master: splits address/length/direction commands into single-word
// SRAM controller requests, with a show-ahead read FIFO. Optional watchdog: SRAM_REQ_TIMEOUT_EN.
module sram_burst_req #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iCmdValid,
    output logic                  oCmdReady,
    input  logic                  iCmdWrite,
    input  logic [ADDR_WIDTH-1:0] iCmdAddr,
    input  logic [LEN_WIDTH-1:0]  iCmdLen,
    input  logic [DATA_WIDTH-1:0] iWrData,
    input  logic                  iWrValid,
    output logic                  oWrReady,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oRdValid,
    input  logic                  iRdReady,
    output logic [ADDR_WIDTH-1:0] oAddress,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValidRequest,
    output logic                  oWrite,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iValidRead,
    output logic                  oBusy,
    output logic                  oDone
`ifdef SRAM_REQ_TIMEOUT_EN
    ,
    output logic                  oTimeout
`endif
);

    // state      | meaning
    // S_IDLE     | waiting for a command, FIFO may still hold read words
    // S_RD_REQ   | read request outstanding
    // S_RD_STALL | read burst paused, FIFO full
    // S_WR_FETCH | waiting for the next write word from the client
    // S_WR_REQ   | write request outstanding
    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_STALL, S_WR_FETCH, S_WR_REQ
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic                    req_q;
    logic                    write_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    room_after;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = iRdReady && (count_q != '0);
    assign push       = (state_q == S_RD_REQ) && iValidRead;
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    assign room_after = (count_d != CNT_W'(FIFO_DEPTH));

    always_ff @(posedge iClock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= iData;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

`ifdef SRAM_REQ_TIMEOUT_EN
    // Loaded so that the request stays up for exactly 255 unanswered cycles.
    localparam logic [7:0] WD_LOAD = 8'd254;
    logic [7:0] wd_q;
    logic       timeout_q;
    assign oTimeout = timeout_q;
`endif

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            req_q   <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SRAM_REQ_TIMEOUT_EN
            wd_q      <= WD_LOAD;
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iCmdValid) begin
                        addr_q  <= iCmdAddr;
                        rem_q   <= iCmdLen;
                        write_q <= iCmdWrite;
`ifdef SRAM_REQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (iCmdWrite) begin
                            state_q <= S_WR_FETCH;
                        end else if (fifo_full && !pop) begin
                            state_q <= S_RD_STALL;
                        end else begin
                            state_q <= S_RD_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (iValidRead) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (rem_q == '0) begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                            write_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rem_q <= rem_q - LEN_WIDTH'(1);
                            if (!room_after) begin
                                state_q <= S_RD_STALL;
                                req_q   <= 1'b0;
                            end
                        end
                    end
                end
                S_RD_STALL: begin
                    if (!fifo_full) begin
                        state_q <= S_RD_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_WR_FETCH: begin
                    if (iWrValid) begin
                        data_q  <= iWrData;
                        state_q <= S_WR_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (iValidRead) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        req_q  <= 1'b0;
                        if (rem_q == '0) begin
                            state_q <= S_IDLE;
                            write_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rem_q   <= rem_q - LEN_WIDTH'(1);
                            state_q <= S_WR_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
`ifdef SRAM_REQ_TIMEOUT_EN
            // Placed after the case so an abort overrides any state update above.
            if (req_q && !iValidRead) begin
                if (wd_q == '0) begin
                    state_q   <= S_IDLE;
                    req_q     <= 1'b0;
                    write_q   <= 1'b0;
                    timeout_q <= 1'b1;
                    wd_q      <= WD_LOAD;
                end else begin
                    wd_q <= wd_q - 8'd1;
                end
            end else begin
                wd_q <= WD_LOAD;
            end
`endif
        end
    end

    assign oCmdReady     = (state_q == S_IDLE);
    assign oWrReady      = (state_q == S_WR_FETCH);
    assign oBusy         = (state_q != S_IDLE);
    assign oDone         = done_q;
    assign oAddress      = addr_q;
    assign oData         = data_q;
    assign oValidRequest = req_q;
    assign oWrite        = write_q;
    assign oRdValid      = (count_q != '0);
    assign oRdData       = oRdValid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sram_burst_req.sv
// Bench for sram_burst_req: controller/client models, a burst vector table and
// hand sequences for FIFO stall, spurious completion, reset abort and the watchdog.
module tb_sram_burst_req;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int FD = 8;

    logic          iClock = 1'b0;
    logic          iReset;
    logic          iCmdValid, oCmdReady, iCmdWrite;
    logic [AW-1:0] iCmdAddr;
    logic [LW-1:0] iCmdLen;
    logic [DW-1:0] iWrData;
    logic          iWrValid, oWrReady;
    logic [DW-1:0] oRdData;
    logic          oRdValid, iRdReady;
    logic [AW-1:0] oAddress;
    logic [DW-1:0] oData;
    logic          oValidRequest, oWrite;
    logic [DW-1:0] iData;
    logic          iValidRead, oBusy, oDone;
`ifdef SRAM_REQ_TIMEOUT_EN
    logic          oTimeout;
`endif

    sram_burst_req #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
        .iClock(iClock), .iReset(iReset),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
        .iCmdAddr(iCmdAddr), .iCmdLen(iCmdLen),
        .iWrData(iWrData), .iWrValid(iWrValid), .oWrReady(oWrReady),
        .oRdData(oRdData), .oRdValid(oRdValid), .iRdReady(iRdReady),
        .oAddress(oAddress), .oData(oData), .oValidRequest(oValidRequest), .oWrite(oWrite),
        .iData(iData), .iValidRead(iValidRead), .oBusy(oBusy), .oDone(oDone)
`ifdef SRAM_REQ_TIMEOUT_EN
        , .oTimeout(oTimeout)
`endif
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit ctrl_en = 1'b0;
    int ctrl_lat = 2;
    int spur_req = 0;

    logic [AW-1:0] req_addr_q [$];
    logic          req_wr_q   [$];
    logic [DW-1:0] req_data_q [$];
    logic [DW-1:0] rd_q       [$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [AW-1:0] exp_end;
        logic [DW-1:0] seed;
        int            lat;
    } vec_t;
    vec_t vecs [7];

    // Controller model: answers each request after ctrl_lat cycles and logs it.
    initial begin
        int lat_cnt;
        int spur_done;
        lat_cnt = 0;
        spur_done = 0;
        iValidRead = 1'b0;
        iData = '0;
        forever begin
            @(posedge iClock); #1;
            iValidRead = 1'b0;
            if (ctrl_en) begin
                if (oValidRequest) begin
                    if (lat_cnt >= ctrl_lat - 1) begin
                        iValidRead = 1'b1;
                        iData = oAddress[DW-1:0] ^ 16'hA5C3;
                        req_addr_q.push_back(oAddress);
                        req_wr_q.push_back(oWrite);
                        req_data_q.push_back(oData);
                        lat_cnt = 0;
                    end else begin
                        lat_cnt++;
                    end
                end else begin
                    lat_cnt = 0;
                end
            end else begin
                lat_cnt = 0;
                if (spur_req != spur_done) begin
                    iValidRead = 1'b1;
                    iData = 16'hDEAD;
                    spur_done++;
                end
            end
        end
    end

    // Client read sink and done counter, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge iClock); #1;
            if (oRdValid && iRdReady) rd_q.push_back(oRdData);
            if (oDone) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock); #1;
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_wr_q.delete();
        req_data_q.delete();
        rd_q.delete();
    endtask

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        iCmdValid = 1'b1;
        iCmdWrite = wr;
        iCmdAddr  = a;
        iCmdLen   = l;
        while (!oCmdReady && n < 100) begin
            tick();
            n++;
        end
        check("cmd_ready_before_accept", oCmdReady, 1);
        tick();
        iCmdValid = 1'b0;
    endtask

    task automatic feed_writes(input logic [DW-1:0] wd [$], input int gap);
        for (int i = 0; i < wd.size(); i++) begin
            int n;
            n = 0;
            while (!oWrReady && n < 200) begin
                tick();
                n++;
            end
            check($sformatf("wr_ready_beat%0d", i), oWrReady, 1);
            repeat (gap) tick();
            iWrValid = 1'b1;
            iWrData  = wd[i];
            tick();
            iWrValid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (oDone) begin
                ok = 1'b1;
                check("busy_low_on_done", oBusy, 0);
                check("cmd_ready_on_done", oCmdReady, 1);
            end
        end
        check("done_seen", ok, 1);
    endtask

    initial begin
        logic [DW-1:0] wq [$];
        logic [DW-1:0] wd_a [$];
        logic [AW-1:0] exp_a [3];
        int d0;
        int n;

        vecs[0] = '{1'b0, 22'h000010, 8'd3, 22'h000014, 16'h0000, 2};
        vecs[1] = '{1'b0, 22'h3FFFFD, 8'd4, 22'h000002, 16'h0000, 3};
        vecs[2] = '{1'b1, 22'h000100, 8'd0, 22'h000101, 16'h1111, 2};
        vecs[3] = '{1'b1, 22'h3FFFFF, 8'd1, 22'h000001, 16'h2468, 1};
        vecs[4] = '{1'b0, 22'h0ABCDE, 8'd0, 22'h0ABCDF, 16'h0000, 1};
        vecs[5] = '{1'b1, 22'h200000, 8'd5, 22'h200006, 16'h7E00, 3};
        vecs[6] = '{1'b0, 22'h000080, 8'd9, 22'h00008A, 16'h0000, 1};
        wd_a = '{16'h00A1, 16'h00B2, 16'h00C3};
        exp_a = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000};

        iReset = 1'b0;
        iCmdValid = 1'b0; iCmdWrite = 1'b0; iCmdAddr = '0; iCmdLen = '0;
        iWrData = '0; iWrValid = 1'b0; iRdReady = 1'b0;
        #1;
        check("rst_flags", {oCmdReady, oWrReady, oRdValid, oValidRequest, oWrite, oBusy, oDone}, 7'b1000000);
        check("rst_addr", oAddress, 0);
        check("rst_data", oData, 0);
        check("rst_rddata", oRdData, 0);
        #21;
        iReset = 1'b1;
        tick();
        check("idle_flags", {oCmdReady, oWrReady, oRdValid, oValidRequest, oWrite, oBusy, oDone}, 7'b1000000);

        // Burst table
        foreach (vecs[k]) begin
            clear_logs();
            wq.delete();
            ctrl_en = 1'b1;
            ctrl_lat = vecs[k].lat;
            iRdReady = 1'b1;
            d0 = done_cnt;
            send_cmd(vecs[k].wr, vecs[k].addr, vecs[k].len);
            if (vecs[k].wr) begin
                check($sformatf("v%0d_accept_wrready", k), oWrReady, 1);
                for (int i = 0; i <= int'(vecs[k].len); i++) wq.push_back(vecs[k].seed ^ DW'(i));
                feed_writes(wq, 0);
            end else begin
                check($sformatf("v%0d_accept_req", k), oValidRequest, 1);
            end
            wait_done(3000);
            repeat (3) tick();
            check($sformatf("v%0d_beats", k), req_addr_q.size(), int'(vecs[k].len) + 1);
            for (int i = 0; i < req_addr_q.size(); i++) begin
                check($sformatf("v%0d_addr%0d", k, i), req_addr_q[i], AW'(vecs[k].addr + i));
                check($sformatf("v%0d_dir%0d", k, i), req_wr_q[i], vecs[k].wr);
                if (vecs[k].wr && i < wq.size())
                    check($sformatf("v%0d_wdata%0d", k, i), req_data_q[i], wq[i]);
            end
            if (vecs[k].wr) begin
                check($sformatf("v%0d_rd_words", k), rd_q.size(), 0);
            end else begin
                check($sformatf("v%0d_rd_words", k), rd_q.size(), int'(vecs[k].len) + 1);
                for (int i = 0; i < rd_q.size(); i++)
                    check($sformatf("v%0d_rdata%0d", k, i), rd_q[i], DW'(AW'(vecs[k].addr + i)) ^ 16'hA5C3);
            end
            check($sformatf("v%0d_end_addr", k), oAddress, vecs[k].exp_end);
            check($sformatf("v%0d_done_pulses", k), done_cnt - d0, 1);
        end

        // Gapped write across the address wrap
        clear_logs();
        ctrl_lat = 2;
        send_cmd(1'b1, 22'h3FFFFE, 8'd2);
        feed_writes(wd_a, 2);
        wait_done(500);
        repeat (2) tick();
        check("wrap_beats", req_addr_q.size(), 3);
        for (int i = 0; i < req_addr_q.size() && i < 3; i++) begin
            check($sformatf("wrap_addr%0d", i), req_addr_q[i], exp_a[i]);
            check($sformatf("wrap_data%0d", i), req_data_q[i], wd_a[i]);
            check($sformatf("wrap_dir%0d", i), req_wr_q[i], 1);
        end

        // FIFO-full stall with client not draining
        clear_logs();
        iRdReady = 1'b0;
        send_cmd(1'b0, 22'h000040, 8'd15);
        repeat (60) tick();
        check("stall_beats", req_addr_q.size(), FD);
        check("stall_req_low", oValidRequest, 0);
        check("stall_busy", oBusy, 1);
        check("stall_rdvalid", oRdValid, 1);
        check("stall_head", oRdData, 16'h0040 ^ 16'hA5C3);
        iRdReady = 1'b1;
        wait_done(500);
        repeat (3) tick();
        check("stall_total_beats", req_addr_q.size(), 16);
        check("stall_words", rd_q.size(), 16);
        for (int i = 0; i < rd_q.size(); i++)
            check($sformatf("stall_rdata%0d", i), rd_q[i], DW'(16'h0040 + i) ^ 16'hA5C3);

        // Spurious completion in IDLE
        ctrl_en = 1'b0;
        tick();
        d0 = done_cnt;
        spur_req++;
        repeat (3) tick();
        check("spur_flags", {oCmdReady, oRdValid, oValidRequest, oBusy, oDone}, 5'b10000);
        check("spur_no_done", done_cnt - d0, 0);

        // Reset during beat 2 of a read burst
        clear_logs();
        ctrl_en = 1'b1;
        ctrl_lat = 3;
        send_cmd(1'b0, 22'h000200, 8'd5);
        n = 0;
        while (req_addr_q.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("beat2_req", oValidRequest, 1);
        check("beat2_addr", oAddress, 22'h000201);
        @(negedge iClock); #2;
        ctrl_en = 1'b0;
        iReset = 1'b0;
        #1;
        check("arst_flags", {oCmdReady, oWrReady, oRdValid, oValidRequest, oWrite, oBusy, oDone}, 7'b1000000);
        check("arst_addr", oAddress, 0);
        check("arst_data", oData, 0);
        check("arst_rddata", oRdData, 0);
        #10;
        iReset = 1'b1;
        tick();
        spur_req++;
        repeat (3) tick();
        check("post_rst_spur", {oCmdReady, oRdValid, oValidRequest, oBusy}, 4'b1000);
        clear_logs();
        ctrl_en = 1'b1;
        ctrl_lat = 1;
        send_cmd(1'b0, 22'h000300, 8'd1);
        wait_done(200);
        repeat (3) tick();
        check("post_rst_beats", req_addr_q.size(), 2);
        check("post_rst_words", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            check("post_rst_w0", rd_q[0], 16'h0300 ^ 16'hA5C3);
            check("post_rst_w1", rd_q[1], 16'h0301 ^ 16'hA5C3);
        end

`ifdef SRAM_REQ_TIMEOUT_EN
        // Controller never answers
        ctrl_en = 1'b0;
        check("to_initial", oTimeout, 0);
        d0 = done_cnt;
        send_cmd(1'b0, 22'h000010, 8'd3);
        n = 0;
        while (oValidRequest && n < 400) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, 255);
        check("to_flag", oTimeout, 1);
        check("to_cmdready", oCmdReady, 1);
        check("to_no_done", done_cnt - d0, 0);
        clear_logs();
        ctrl_en = 1'b1;
        ctrl_lat = 2;
        send_cmd(1'b1, 22'h000020, 8'd0);
        check("to_cleared", oTimeout, 0);
        wq.delete();
        wq.push_back(16'h5555);
        feed_writes(wq, 0);
        wait_done(200);
        check("to_recover_beats", req_addr_q.size(), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
